mem_burst_generator: RTL and testbench



---
 rtl/mem_burst_generator.sv | 116 +++++++++++
 tb/tb_mem_burst_generator.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_burst_generator.sv
`default_nettype none
// ============================================================================
// Module  : mem_burst_generator
// Brief   : Splits a sub-4KB write request into INCR AXI write-address bursts.
// Revision: 1.0 - initial release
// ============================================================================
module mem_burst_generator #(
   parameter int ADDR_WIDTH      = 64,
   parameter int REQ_SIZE_WIDTH  = 16,
   parameter int AXI_DATA_WIDTH  = 512,
   parameter int AXI_BURST_WIDTH = 8,
   parameter int MAX_BURST_LEN   = 16
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic [ADDR_WIDTH-1:0]      req_addr,
   input  logic                       req_valid,
   input  logic [REQ_SIZE_WIDTH-1:0]  req_size_bytes,
   output logic                       req_ready,
   output logic [ADDR_WIDTH-1:0]      axi_awaddr,
   output logic [AXI_BURST_WIDTH-1:0] axi_awlen,
   output logic [2:0]                 axi_awsize,
   output logic [1:0]                 axi_awburst,
   output logic                       axi_awvalid,
   input  logic                       axi_awready,
   output logic                       burst_busy,
   output logic                       req_done
);

   localparam int BEAT_BYTES = AXI_DATA_WIDTH / 8;
   localparam int SHIFT      = $clog2(BEAT_BYTES);
   localparam int RW         = REQ_SIZE_WIDTH + 1;
   localparam int LEN_W      = $clog2(MAX_BURST_LEN) + 1;
   localparam logic [RW-1:0]         MAX_RW    = RW'(MAX_BURST_LEN);
   localparam logic [ADDR_WIDTH-1:0] ADDR_MASK = ~(ADDR_WIDTH'(BEAT_BYTES - 1));

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_LOAD  = 2'd1;
   localparam logic [1:0] S_ISSUE = 2'd2;
   localparam logic [1:0] S_DONE  = 2'd3;

   logic [1:0]                 state;
   logic [ADDR_WIDTH-1:0]      addr;
   logic [RW-1:0]              remaining;
   logic [LEN_W-1:0]           len;
   logic [AXI_BURST_WIDTH-1:0] awlen;

   logic [RW-1:0]              beats_in;
   logic [RW-1:0]              rem_after;
   logic [RW-1:0]              min_src;
   logic [LEN_W-1:0]           next_len;
   logic                       handshake;

   always_comb begin
      beats_in  = ({1'b0, req_size_bytes} + RW'(BEAT_BYTES - 1)) >> SHIFT;
      rem_after = remaining - RW'(len);
      // In ISSUE the next length is derived from the post-handshake count so
      // back-to-back bursts need no extra cycle.
      min_src   = (state == S_ISSUE) ? rem_after : remaining;
      next_len  = (min_src > MAX_RW) ? LEN_W'(MAX_BURST_LEN) : min_src[LEN_W-1:0];
      handshake = (state == S_ISSUE) && axi_awready;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= S_IDLE;
         addr      <= '0;
         remaining <= '0;
         len       <= '0;
         awlen     <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (req_valid) begin
                  addr      <= req_addr & ADDR_MASK;
                  remaining <= beats_in;
                  state     <= S_LOAD;
               end
            end
            S_LOAD: begin
               len   <= next_len;
               awlen <= AXI_BURST_WIDTH'(next_len - LEN_W'(1));
               state <= (remaining != '0) ? S_ISSUE : S_DONE;
            end
            S_ISSUE: begin
               if (handshake) begin
                  addr      <= addr + (ADDR_WIDTH'(len) << SHIFT);
                  remaining <= rem_after;
                  len       <= next_len;
                  awlen     <= AXI_BURST_WIDTH'(next_len - LEN_W'(1));
                  if (rem_after == '0) begin
                     state <= S_DONE;
                  end
               end
            end
            S_DONE: begin
               state <= S_IDLE;
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

   assign req_ready   = (state == S_IDLE);
   assign axi_awvalid = (state == S_ISSUE);
   assign req_done    = (state == S_DONE);
   assign burst_busy  = (state != S_IDLE);
   assign axi_awaddr  = addr;
   assign axi_awlen   = awlen;
   assign axi_awsize  = 3'(SHIFT);
   assign axi_awburst = 2'b01;

endmodule
`default_nettype wire

// File: tb/tb_mem_burst_generator.sv
`default_nettype none
// ============================================================================
// Module  : tb_mem_burst_generator
// Brief   : Directed and randomized checks of mem_burst_generator.
// Revision: 1.0 - initial release
// ============================================================================
module tb_mem_burst_generator;

   logic        clk = 1'b0;
   logic        reset;
   logic [63:0] req_addr;
   logic        req_valid;
   logic [15:0] req_size_bytes;
   logic        req_ready;
   logic [63:0] axi_awaddr;
   logic [7:0]  axi_awlen;
   logic [2:0]  axi_awsize;
   logic [1:0]  axi_awburst;
   logic        axi_awvalid;
   logic        axi_awready;
   logic        burst_busy;
   logic        req_done;

   int tests = 0;
   int fails = 0;

   mem_burst_generator dut (
      .clk            (clk),
      .reset          (reset),
      .req_addr       (req_addr),
      .req_valid      (req_valid),
      .req_size_bytes (req_size_bytes),
      .req_ready      (req_ready),
      .axi_awaddr     (axi_awaddr),
      .axi_awlen      (axi_awlen),
      .axi_awsize     (axi_awsize),
      .axi_awburst    (axi_awburst),
      .axi_awvalid    (axi_awvalid),
      .axi_awready    (axi_awready),
      .burst_busy     (burst_busy),
      .req_done       (req_done)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_flags(input string tag, input logic v, input logic rdy,
                              input logic busy, input logic done);
      check({tag, ".awvalid"}, 64'(axi_awvalid), 64'(v));
      check({tag, ".req_ready"}, 64'(req_ready), 64'(rdy));
      check({tag, ".burst_busy"}, 64'(burst_busy), 64'(busy));
      check({tag, ".req_done"}, 64'(req_done), 64'(done));
   endtask

   // Reference: list of (address, awlen) bursts a request must produce.
   logic [63:0] exp_addr[$];
   logic [7:0]  exp_len[$];

   task automatic build_model(input logic [63:0] a, input logic [15:0] s);
      logic [63:0] base;
      int beats;
      int l;
      exp_addr.delete();
      exp_len.delete();
      base  = a & ~64'h3F;
      beats = (int'(s) + 63) / 64;
      while (beats > 0) begin
         l = (beats > 16) ? 16 : beats;
         exp_addr.push_back(base);
         exp_len.push_back(8'(l - 1));
         base  = base + 64'(l * 64);
         beats = beats - l;
      end
   endtask

   // Drives one request and checks the full cycle-by-cycle response.
   task automatic do_req(input string tag, input logic [63:0] a, input logic [15:0] s,
                         input int stall_pct, input int fixed_stall);
      int stalls = 0;
      int consec = 0;
      int guard  = 0;
      logic rdy;
      build_model(a, s);
      @(negedge clk);
      req_addr       = a;
      req_size_bytes = s;
      req_valid      = 1'b1;
      check_flags({tag, ".idle"}, 1'b0, 1'b1, 1'b0, 1'b0);
      @(negedge clk);
      // Junk request while busy must be ignored.
      req_addr       = 64'(~a);
      req_size_bytes = 16'h0FC0;
      axi_awready    = 1'($urandom_range(0, 1));
      check_flags({tag, ".load"}, 1'b0, 1'b0, 1'b1, 1'b0);
      while (exp_addr.size() > 0) begin
         @(negedge clk);
         guard++;
         if (guard > 300) begin
            check({tag, ".timeout"}, 64'(guard), 64'd300);
            break;
         end
         check_flags({tag, ".issue"}, 1'b1, 1'b0, 1'b1, 1'b0);
         check({tag, ".awaddr"}, axi_awaddr, exp_addr[0]);
         check({tag, ".awlen"}, 64'(axi_awlen), 64'(exp_len[0]));
         if (stalls < fixed_stall) begin
            rdy = 1'b0;
            stalls++;
         end else begin
            rdy = ($urandom_range(0, 99) >= stall_pct) || (consec >= 8);
         end
         consec      = rdy ? 0 : consec + 1;
         axi_awready = rdy;
         if (rdy) begin
            void'(exp_addr.pop_front());
            void'(exp_len.pop_front());
         end
      end
      @(negedge clk);
      axi_awready = 1'b0;
      req_valid   = 1'b0;
      check_flags({tag, ".done"}, 1'b0, 1'b0, 1'b1, 1'b1);
      @(negedge clk);
      check_flags({tag, ".back_idle"}, 1'b0, 1'b1, 1'b0, 1'b0);
   endtask

   initial begin
      logic [63:0] ra;
      logic [15:0] rs;
      int off;
      reset          = 1'b1;
      req_addr       = '0;
      req_valid      = 1'b0;
      req_size_bytes = '0;
      axi_awready    = 1'b0;
      repeat (2) @(negedge clk);
      check_flags("reset", 1'b0, 1'b1, 1'b0, 1'b0);
      check("reset.awaddr", axi_awaddr, 64'h0);
      check("reset.awlen", 64'(axi_awlen), 64'h0);
      check("awsize", 64'(axi_awsize), 64'd6);
      check("awburst", 64'(axi_awburst), 64'd1);
      reset = 1'b0;

      do_req("single", 64'h1000, 16'd256, 0, 0);
      do_req("two_bursts", 64'h2000, 16'd1600, 0, 0);
      do_req("unaligned", 64'h3040, 16'd100, 0, 0);
      do_req("stall5", 64'h1000, 16'd1024, 0, 5);
      do_req("zero", 64'h5000, 16'd0, 0, 0);
      do_req("full_page", 64'h7000, 16'd4096, 30, 0);
      do_req("one_byte", 64'h803F, 16'd1, 50, 2);

      // Reset during the second burst of the two-burst request.
      build_model(64'h2000, 16'd1600);
      @(negedge clk);
      req_addr = 64'h2000; req_size_bytes = 16'd1600; req_valid = 1'b1;
      @(negedge clk);
      req_valid = 1'b0;
      @(negedge clk);
      check("rst.burst1.awaddr", axi_awaddr, 64'h2000);
      axi_awready = 1'b1;
      @(negedge clk);
      axi_awready = 1'b0;
      check("rst.burst2.awaddr", axi_awaddr, 64'h2400);
      check("rst.burst2.awlen", 64'(axi_awlen), 64'd8);
      check("rst.burst2.awvalid", 64'(axi_awvalid), 64'd1);
      #1 reset = 1'b1;
      #1;
      check_flags("rst.async", 1'b0, 1'b1, 1'b0, 1'b0);
      check("rst.async.awaddr", axi_awaddr, 64'h0);
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      check_flags("rst.after", 1'b0, 1'b1, 1'b0, 1'b0);
      do_req("post_reset", 64'h9100, 16'd200, 20, 0);

      for (int i = 0; i < 40; i++) begin
         off = $urandom_range(0, 4095);
         rs  = 16'($urandom_range(0, 4096 - off));
         ra  = {20'($urandom), 32'($urandom), 12'(off)};
         do_req($sformatf("rand%0d", i), ra, rs, $urandom_range(0, 60), $urandom_range(0, 2));
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire
